// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory controller and its lane aligner.
package dmem_pkg;

    typedef enum logic [2:0] {
        MW_B  = 3'b000,
        MW_H  = 3'b001,
        MW_W  = 3'b010,
        MW_BU = 3'b100,
        MW_HU = 3'b101
    } mem_width_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } dmem_state_e;

    localparam logic [31:0] DEFAULT_MMIO_ADDR = 32'h0000_0100;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store enables/replicated data, load extraction/extension, alignment checks.
// Purely combinational.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  st_width_i,
    input  logic [1:0]  st_lane_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_data_o,
    output logic        illegal_o,
    output logic        misalign_o,
    input  logic [2:0]  ld_width_i,
    input  logic [1:0]  ld_lane_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        illegal_o  = 1'b0;
        misalign_o = 1'b0;
        st_be_o    = 4'b0000;
        st_data_o  = st_data_i;
        case (mem_width_e'(st_width_i))
            MW_B, MW_BU: begin
                st_be_o   = 4'b0001 << st_lane_i;
                st_data_o = {4{st_data_i[7:0]}};
            end
            MW_H, MW_HU: begin
                st_be_o    = st_lane_i[1] ? 4'b1100 : 4'b0011;
                st_data_o  = {2{st_data_i[15:0]}};
                misalign_o = st_lane_i[0];
            end
            MW_W: begin
                st_be_o    = 4'b1111;
                misalign_o = |st_lane_i;
            end
            default: illegal_o = 1'b1;
        endcase
    end

    always_comb begin
        byte_sel  = ld_word_i[{ld_lane_i, 3'b000} +: 8];
        half_sel  = ld_lane_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        ld_data_o = ld_word_i;
        case (mem_width_e'(ld_width_i))
            MW_B:    ld_data_o = {{24{byte_sel[7]}}, byte_sel};
            MW_BU:   ld_data_o = {24'h0, byte_sel};
            MW_H:    ld_data_o = {{16{half_sel[15]}}, half_sel};
            MW_HU:   ld_data_o = {16'h0, half_sel};
            default: ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-port word array with byte/half/word access, one MMIO output register and fault counting.
// Load latency 1; response held while rsp_ready is low, a new request is accepted only as the old one retires.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_ADDR   = DEFAULT_MMIO_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_width,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [31:0] mmio_out,
    output logic        mmio_wr,
    output logic [15:0] fault_count
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    dmem_state_e   state_q, state_d;
    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [31:0]   rd_word_q;
    logic [2:0]    ld_width_q;
    logic [1:0]    ld_lane_q;
    logic          ld_en_q;
    logic          rsp_fault_q;
    logic [31:0]   mmio_q;
    logic          mmio_wr_q;
    logic [15:0]   fault_cnt_q;

    logic          accept, is_mmio, out_of_range, fault, illegal, misalign;
    logic          mem_we, mmio_st;
    logic [AW-1:0] idx;
    logic [3:0]    st_be;
    logic [31:0]   st_data, ld_data;

    dmem_lane_align u_align (
        .st_width_i (req_width),
        .st_lane_i  (req_addr[1:0]),
        .st_data_i  (req_wdata),
        .st_be_o    (st_be),
        .st_data_o  (st_data),
        .illegal_o  (illegal),
        .misalign_o (misalign),
        .ld_width_i (ld_width_q),
        .ld_lane_i  (ld_lane_q),
        .ld_word_i  (rd_word_q),
        .ld_data_o  (ld_data)
    );

    assign req_ready    = (state_q == ST_IDLE) | rsp_ready;
    assign accept       = req_valid & req_ready;
    assign is_mmio      = (req_addr == MMIO_ADDR);
    // The MMIO address wins even when it aliases a word inside the array.
    assign out_of_range = !is_mmio && (req_addr[31:2] >= 30'(DEPTH_WORDS));
    assign fault        = illegal | misalign | out_of_range | (is_mmio & (req_width != MW_W));
    assign idx          = req_addr[AW+1:2];
    assign mem_we       = accept & req_we & ~fault & ~is_mmio;
    assign mmio_st      = req_we & is_mmio & ~fault;

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = ST_RESP;
        end else if (rsp_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) begin
                    mem_q[idx][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd_word_q   <= 32'h0;
            ld_width_q  <= 3'b000;
            ld_lane_q   <= 2'b00;
            ld_en_q     <= 1'b0;
            rsp_fault_q <= 1'b0;
            mmio_q      <= 32'h0;
            mmio_wr_q   <= 1'b0;
            fault_cnt_q <= 16'h0;
        end else begin
            state_q   <= state_d;
            mmio_wr_q <= accept & mmio_st;
            if (accept) begin
                rd_word_q   <= is_mmio ? mmio_q : mem_q[idx];
                ld_width_q  <= req_width;
                ld_lane_q   <= req_addr[1:0];
                ld_en_q     <= ~req_we & ~fault;
                rsp_fault_q <= fault;
                if (mmio_st) begin
                    mmio_q <= req_wdata;
                end
                if (fault && (fault_cnt_q != 16'hFFFF)) begin
                    fault_cnt_q <= fault_cnt_q + 16'h1;
                end
            end
        end
    end

    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_rdata   = ld_en_q ? ld_data : 32'h0;
    assign rsp_fault   = rsp_fault_q;
    assign mmio_out    = mmio_q;
    assign mmio_wr     = mmio_wr_q;
    assign fault_count = fault_cnt_q;

endmodule
